// File: rtl/uart_wb_bridge.sv
// UART byte-stream to Wishbone pipelined single-transfer master.
// Assembles 'W'/'R' command frames from RX bytes, runs one bus cycle, reports status and read data over TX.
module uart_wb_bridge #(
   parameter int ADDR_W        = 30,
   parameter int DATA_W        = 32,
   parameter int WB_TIMEOUT    = 1023,
   parameter int FRAME_TIMEOUT = 12000
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [7:0]          i_rx_data,
   input  logic                i_rx_valid,
   output logic                o_rx_clear,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_stb,
   input  logic                i_tx_busy,
   output logic                o_wb_cyc,
   output logic                o_wb_stb,
   output logic                o_wb_we,
   output logic [ADDR_W-1:0]   o_wb_addr,
   output logic [DATA_W-1:0]   o_wb_data,
   output logic [DATA_W/8-1:0] o_wb_sel,
   input  logic                i_wb_stall,
   input  logic                i_wb_ack,
   input  logic                i_wb_err,
   input  logic [DATA_W-1:0]   i_wb_data,
   output logic                o_busy
);

   localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
   localparam int DATA_BYTES = DATA_W / 8;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_UNK  = 8'h3F;
   localparam logic [7:0] RSP_RD   = 8'h72;
   localparam logic [7:0] RSP_WR   = 8'h6B;
   localparam logic [7:0] RSP_ERR  = 8'h65;

   localparam logic [7:0]  ADDR_LAST  = 8'(ADDR_BYTES - 1);
   localparam logic [7:0]  DATA_LAST  = 8'(DATA_BYTES - 1);
   localparam logic [31:0] WB_LAST    = 32'(WB_TIMEOUT - 1);
   localparam logic [31:0] FRAME_LAST = 32'(FRAME_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_BUS_REQ, S_BUS_WAIT, S_RSP_HDR, S_RSP_DATA
   } state_t;

   state_t             state;
   logic [7:0]         byte_cnt;
   logic [31:0]        idle_cnt;
   logic [31:0]        tmo_cnt;
   logic               is_wr;
   logic [7:0]         rsp_code;
   logic [DATA_W-1:0]  rsp_r;
   logic               tx_out;
   logic               tx_seen_busy;
   logic               rx_take;
   logic               tx_ready;

   // A byte already acknowledged by o_rx_clear must not be taken again while RXNE is still falling.
   assign rx_take  = i_rx_valid && !o_rx_clear &&
                     (state == S_IDLE || state == S_ADDR || state == S_DATA);
   assign tx_ready = !i_tx_busy && !tx_out;
   assign o_wb_sel = '1;
   assign o_busy   = (state != S_IDLE);

   always_ff @(posedge i_clk) begin
      o_rx_clear <= 1'b0;
      o_tx_stb   <= 1'b0;
      if (i_reset) begin
         state        <= S_IDLE;
         byte_cnt     <= '0;
         idle_cnt     <= '0;
         tmo_cnt      <= '0;
         is_wr        <= 1'b0;
         rsp_code     <= '0;
         tx_out       <= 1'b0;
         tx_seen_busy <= 1'b0;
         o_tx_data    <= '0;
         o_wb_cyc     <= 1'b0;
         o_wb_stb     <= 1'b0;
         o_wb_we      <= 1'b0;
         o_wb_addr    <= '0;
         o_wb_data    <= '0;
      end else begin
         // Outstanding TX byte retires only after busy has been seen high and then low again.
         if (tx_out) begin
            if (i_tx_busy)
               tx_seen_busy <= 1'b1;
            else if (tx_seen_busy)
               tx_out <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (rx_take) begin
                  o_rx_clear <= 1'b1;
                  byte_cnt   <= '0;
                  idle_cnt   <= '0;
                  if (i_rx_data == OP_WRITE || i_rx_data == OP_READ) begin
                     is_wr <= (i_rx_data == OP_WRITE);
                     state <= S_ADDR;
                  end else begin
                     rsp_code <= RSP_UNK;
                     state    <= S_RSP_HDR;
                  end
               end
            end

            S_ADDR: begin
               if (rx_take) begin
                  o_rx_clear <= 1'b1;
                  idle_cnt   <= '0;
                  o_wb_addr  <= ADDR_W'({o_wb_addr, i_rx_data});
                  if (byte_cnt == ADDR_LAST) begin
                     byte_cnt <= '0;
                     if (is_wr) begin
                        state <= S_DATA;
                     end else begin
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_wb_we  <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= S_BUS_REQ;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 8'd1;
                  end
               end else if (idle_cnt == FRAME_LAST) begin
                  state <= S_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 32'd1;
               end
            end

            S_DATA: begin
               if (rx_take) begin
                  o_rx_clear <= 1'b1;
                  idle_cnt   <= '0;
                  o_wb_data  <= DATA_W'({o_wb_data, i_rx_data});
                  if (byte_cnt == DATA_LAST) begin
                     byte_cnt <= '0;
                     o_wb_cyc <= 1'b1;
                     o_wb_stb <= 1'b1;
                     o_wb_we  <= 1'b1;
                     tmo_cnt  <= '0;
                     state    <= S_BUS_REQ;
                  end else begin
                     byte_cnt <= byte_cnt + 8'd1;
                  end
               end else if (idle_cnt == FRAME_LAST) begin
                  state <= S_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 32'd1;
               end
            end

            // err outranks ack; a response during a stalled request ends the cycle just the same.
            S_BUS_REQ, S_BUS_WAIT: begin
               tmo_cnt <= tmo_cnt + 32'd1;
               if (i_wb_err || i_wb_ack) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  o_wb_we  <= 1'b0;
                  state    <= S_RSP_HDR;
                  if (i_wb_err) begin
                     rsp_code <= RSP_ERR;
                  end else begin
                     rsp_code <= is_wr ? RSP_WR : RSP_RD;
                     rsp_r    <= i_wb_data;
                  end
               end else if (tmo_cnt == WB_LAST) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  o_wb_we  <= 1'b0;
                  rsp_code <= RSP_ERR;
                  state    <= S_RSP_HDR;
               end else if (state == S_BUS_REQ && !i_wb_stall) begin
                  o_wb_stb <= 1'b0;
                  state    <= S_BUS_WAIT;
               end
            end

            S_RSP_HDR: begin
               if (tx_ready) begin
                  o_tx_data    <= rsp_code;
                  o_tx_stb     <= 1'b1;
                  tx_out       <= 1'b1;
                  tx_seen_busy <= 1'b0;
                  byte_cnt     <= '0;
                  state        <= (rsp_code == RSP_RD) ? S_RSP_DATA : S_IDLE;
               end
            end

            S_RSP_DATA: begin
               if (tx_ready) begin
                  o_tx_data    <= rsp_r[DATA_W-1 -: 8];
                  o_tx_stb     <= 1'b1;
                  tx_out       <= 1'b1;
                  tx_seen_busy <= 1'b0;
                  rsp_r        <= rsp_r << 8;
                  if (byte_cnt == DATA_LAST)
                     state <= S_IDLE;
                  else
                     byte_cnt <= byte_cnt + 8'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: UART RX driver, busy-modelling TX sink and a scripted Wishbone slave.
module tb_uart_wb_bridge;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int WB_TO  = 20;
   localparam int FR_TO  = 40;

   localparam int M_ACK  = 0;
   localparam int M_ERR  = 1;
   localparam int M_BOTH = 2;
   localparam int M_NONE = 3;

   logic                clk = 1'b0;
   logic                i_reset;
   logic [7:0]          i_rx_data;
   logic                i_rx_valid;
   logic                o_rx_clear;
   logic [7:0]          o_tx_data;
   logic                o_tx_stb;
   logic                i_tx_busy;
   logic                o_wb_cyc;
   logic                o_wb_stb;
   logic                o_wb_we;
   logic [ADDR_W-1:0]   o_wb_addr;
   logic [DATA_W-1:0]   o_wb_data;
   logic [DATA_W/8-1:0] o_wb_sel;
   logic                i_wb_stall;
   logic                i_wb_ack;
   logic                i_wb_err;
   logic [DATA_W-1:0]   i_wb_data;
   logic                o_busy;

   int tests = 0;
   int fails = 0;

   uart_wb_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_TIMEOUT(WB_TO), .FRAME_TIMEOUT(FR_TO)
   ) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_clear(o_rx_clear),
      .o_tx_data(o_tx_data), .o_tx_stb(o_tx_stb), .i_tx_busy(i_tx_busy),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
      .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
      .i_wb_data(i_wb_data), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   // UART TX sink: records bytes, holds busy for 4 cycles per byte.
   logic [7:0] tx_q[$];
   int         tx_busy_cnt = 0;
   int         tx_viol = 0;
   always @(negedge clk) begin
      if (o_tx_stb) begin
         if (i_tx_busy) tx_viol++;
         tx_q.push_back(o_tx_data);
         tx_busy_cnt = 4;
      end else if (tx_busy_cnt > 0) begin
         tx_busy_cnt--;
      end
      i_tx_busy = (tx_busy_cnt != 0);
   end

   int rx_clr_cnt = 0;
   always @(negedge clk) if (o_rx_clear) rx_clr_cnt++;

   // Wishbone slave driven at negedge from the settled bus state.
   int                stall_n = 0;
   int                mode = M_ACK;
   logic [DATA_W-1:0] rd_data = '0;
   int                stb_cycles = 0, cyc_cycles = 0;
   int                last_stb = 0, last_cyc = 0;
   int                n_xfer = 0;
   bit                responded = 0;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;
   logic              cap_we;
   logic [3:0]        cap_sel;
   always @(negedge clk) begin
      i_wb_stall = 1'b0;
      i_wb_ack   = 1'b0;
      i_wb_err   = 1'b0;
      i_wb_data  = '0;
      if (o_wb_cyc) begin
         cyc_cycles++;
         last_cyc = cyc_cycles;
         if (o_wb_stb) begin
            stb_cycles++;
            last_stb = stb_cycles;
            if (stb_cycles <= stall_n) begin
               i_wb_stall = 1'b1;
            end else begin
               cap_addr = o_wb_addr;
               cap_data = o_wb_data;
               cap_we   = o_wb_we;
               cap_sel  = o_wb_sel;
               n_xfer++;
            end
         end else if (!responded) begin
            responded = 1;
            case (mode)
               M_ACK:  begin i_wb_ack = 1'b1; i_wb_data = rd_data; end
               M_ERR:  i_wb_err = 1'b1;
               M_BOTH: begin i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_data = rd_data; end
               default: ;
            endcase
         end
      end else begin
         stb_cycles = 0;
         cyc_cycles = 0;
         responded  = 0;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit hold);
      bit got = 0;
      @(negedge clk);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (o_rx_clear) got = 1;
      end
      if (hold) @(negedge clk);
      i_rx_valid = 1'b0;
      if (!got) begin
         tests++; fails++;
         $display("FAIL rx_take byte %h: o_rx_clear never pulsed, required one pulse", b);
      end
   endtask

   task automatic wait_tx(input int n);
      for (int k = 0; k < 300 && tx_q.size() < n; k++) @(negedge clk);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300 && o_busy; k++) @(negedge clk);
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0;
      repeat (3) @(negedge clk);
      tests++; if (o_wb_cyc !== 1'b0) begin fails++; $display("FAIL reset_cyc got %b want 0", o_wb_cyc); end
      tests++; if (o_wb_stb !== 1'b0) begin fails++; $display("FAIL reset_stb got %b want 0", o_wb_stb); end
      tests++; if (o_wb_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", o_wb_we); end
      tests++; if (o_wb_addr !== '0) begin fails++; $display("FAIL reset_addr got %h want 0", o_wb_addr); end
      tests++; if (o_wb_data !== '0) begin fails++; $display("FAIL reset_wdata got %h want 0", o_wb_data); end
      tests++; if (o_wb_sel !== 4'hF) begin fails++; $display("FAIL reset_sel got %h want f", o_wb_sel); end
      tests++; if (o_tx_stb !== 1'b0) begin fails++; $display("FAIL reset_tx_stb got %b want 0", o_tx_stb); end
      tests++; if (o_tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", o_tx_data); end
      tests++; if (o_rx_clear !== 1'b0) begin fails++; $display("FAIL reset_rx_clear got %b want 0", o_rx_clear); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", o_busy); end
      i_reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      logic [7:0] fr[9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      tx_q.delete(); stall_n = 0; mode = M_ACK; n_xfer = 0;
      foreach (fr[i]) send_byte(fr[i], 1'b0);
      wait_tx(1);
      wait_idle();
      tests++; if (n_xfer !== 1) begin fails++; $display("FAIL wr_xfers got %0d want 1", n_xfer); end
      tests++; if (cap_addr !== 30'h10) begin fails++; $display("FAIL wr_addr got %h want 10", cap_addr); end
      tests++; if (cap_data !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_data got %h want deadbeef", cap_data); end
      tests++; if (cap_we !== 1'b1) begin fails++; $display("FAIL wr_we got %b want 1", cap_we); end
      tests++; if (cap_sel !== 4'hF) begin fails++; $display("FAIL wr_sel got %h want f", cap_sel); end
      tests++; if (last_stb !== 1) begin fails++; $display("FAIL wr_stb_cycles got %0d want 1", last_stb); end
      tests++; if (tx_q.size() !== 1) begin fails++; $display("FAIL wr_tx_count got %0d want 1", tx_q.size()); end
      tests++; if (tx_q.size() == 0 || tx_q[0] !== 8'h6B) begin fails++; $display("FAIL wr_tx_byte got %h want 6b", (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
   endtask

   task automatic test_read_stall();
      logic [7:0] fr[5]  = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
      logic [7:0] exp[5] = '{8'h72, 8'h12, 8'h34, 8'h56, 8'h78};
      int clr0;
      tx_q.delete(); stall_n = 2; mode = M_ACK; rd_data = 32'h12345678; n_xfer = 0;
      clr0 = rx_clr_cnt;
      foreach (fr[i]) send_byte(fr[i], 1'b1);
      wait_tx(5);
      wait_idle();
      tests++; if (rx_clr_cnt - clr0 !== 5) begin fails++; $display("FAIL rx_clear_pulses got %0d want 5", rx_clr_cnt - clr0); end
      tests++; if (cap_addr !== 30'h20) begin fails++; $display("FAIL rd_addr got %h want 20", cap_addr); end
      tests++; if (cap_we !== 1'b0) begin fails++; $display("FAIL rd_we got %b want 0", cap_we); end
      tests++; if (last_stb !== 3) begin fails++; $display("FAIL rd_stb_cycles got %0d want 3", last_stb); end
      tests++; if (tx_q.size() !== 5) begin fails++; $display("FAIL rd_tx_count got %0d want 5", tx_q.size()); end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (i >= tx_q.size() || tx_q[i] !== exp[i]) begin
            fails++;
            $display("FAIL rd_tx_byte%0d got %h want %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp[i]);
         end
      end
      stall_n = 0;
   endtask

   task automatic test_bus_timeout();
      logic [7:0] fr[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h30};
      tx_q.delete(); stall_n = 0; mode = M_NONE;
      foreach (fr[i]) send_byte(fr[i], 1'b0);
      wait_tx(1);
      wait_idle();
      tests++; if (last_cyc !== WB_TO) begin fails++; $display("FAIL tmo_cyc_cycles got %0d want %0d", last_cyc, WB_TO); end
      tests++; if (tx_q.size() !== 1) begin fails++; $display("FAIL tmo_tx_count got %0d want 1", tx_q.size()); end
      tests++; if (tx_q.size() == 0 || tx_q[0] !== 8'h65) begin fails++; $display("FAIL tmo_tx_byte got %h want 65", (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
   endtask

   task automatic test_ack_err();
      logic [7:0] fr[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h34};
      tx_q.delete(); stall_n = 0; mode = M_BOTH; rd_data = 32'hCAFEF00D;
      foreach (fr[i]) send_byte(fr[i], 1'b0);
      wait_tx(1);
      wait_idle();
      tests++; if (last_cyc !== 2) begin fails++; $display("FAIL both_cyc_cycles got %0d want 2", last_cyc); end
      tests++; if (tx_q.size() !== 1) begin fails++; $display("FAIL both_tx_count got %0d want 1", tx_q.size()); end
      tests++; if (tx_q.size() == 0 || tx_q[0] !== 8'h65) begin fails++; $display("FAIL both_tx_byte got %h want 65", (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
      mode = M_ACK;
   endtask

   task automatic test_bad_opcode();
      tx_q.delete(); n_xfer = 0;
      send_byte(8'h41, 1'b0);
      wait_tx(1);
      wait_idle();
      tests++; if (tx_q.size() == 0 || tx_q[0] !== 8'h3F) begin fails++; $display("FAIL badop_tx_byte got %h want 3f", (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
      tests++; if (n_xfer !== 0) begin fails++; $display("FAIL badop_xfers got %0d want 0", n_xfer); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL badop_busy got %b want 0", o_busy); end
   endtask

   task automatic test_frame_timeout();
      logic [7:0] fr[9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h44, 8'h01, 8'h02, 8'h03, 8'h04};
      tx_q.delete(); n_xfer = 0; mode = M_ACK;
      send_byte(8'h57, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      repeat (30) @(negedge clk);
      tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL frto_busy_early got %b want 1", o_busy); end
      repeat (20) @(negedge clk);
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL frto_busy_late got %b want 0", o_busy); end
      tests++; if (n_xfer !== 0) begin fails++; $display("FAIL frto_xfers got %0d want 0", n_xfer); end
      tests++; if (tx_q.size() !== 0) begin fails++; $display("FAIL frto_tx_count got %0d want 0", tx_q.size()); end
      foreach (fr[i]) send_byte(fr[i], 1'b0);
      wait_tx(1);
      wait_idle();
      tests++; if (n_xfer !== 1) begin fails++; $display("FAIL frto_next_xfers got %0d want 1", n_xfer); end
      tests++; if (cap_addr !== 30'h44) begin fails++; $display("FAIL frto_next_addr got %h want 44", cap_addr); end
      tests++; if (cap_data !== 32'h01020304) begin fails++; $display("FAIL frto_next_data got %h want 01020304", cap_data); end
      tests++; if (tx_q.size() == 0 || tx_q[0] !== 8'h6B) begin fails++; $display("FAIL frto_next_tx got %h want 6b", (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
   endtask

   task automatic test_reset_bus_wait();
      logic [7:0] fr[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
      bit seen = 0;
      tx_q.delete(); stall_n = 0; mode = M_NONE;
      foreach (fr[i]) send_byte(fr[i], 1'b0);
      for (int k = 0; k < 20 && !seen; k++) begin
         if (o_wb_cyc && !o_wb_stb) seen = 1;
         else @(negedge clk);
      end
      tests++; if (!seen) begin fails++; $display("FAIL rstw_reach_wait got 0 want 1"); end
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      tests++; if (o_wb_cyc !== 1'b0) begin fails++; $display("FAIL rstw_cyc got %b want 0", o_wb_cyc); end
      tests++; if (o_wb_stb !== 1'b0) begin fails++; $display("FAIL rstw_stb got %b want 0", o_wb_stb); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL rstw_busy got %b want 0", o_busy); end
      repeat (40) @(negedge clk);
      tests++; if (tx_q.size() !== 0) begin fails++; $display("FAIL rstw_tx_count got %0d want 0", tx_q.size()); end
      tests++; if (o_wb_cyc !== 1'b0) begin fails++; $display("FAIL rstw_cyc_later got %b want 0", o_wb_cyc); end
      mode = M_ACK;
   endtask

   task automatic test_tx_rules();
      tests++; if (tx_viol !== 0) begin fails++; $display("FAIL tx_stb_while_busy got %0d want 0", tx_viol); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_stall();
      test_bus_timeout();
      test_ack_err();
      test_bad_opcode();
      test_frame_timeout();
      test_reset_bus_wait();
      test_tx_rules();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
